// File: rtl/detector_scheduler.sv
// Two-requester round-robin scheduler that streams the granted word LSB first
// through an external Moore detector and collects its one-cycle-late response.
module detector_scheduler #(
    parameter int N_BITS = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              req0,
    input  logic              req1,
    input  logic [N_BITS-1:0] data0,
    input  logic [N_BITS-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              busy,
    output logic              done,
    output logic              owner,
    output logic [N_BITS-1:0] hit_vec,
    output logic [CNT_W-1:0]  hit_count,
    output logic              det_x,
    output logic              det_clr_n,
    input  logic              det_y,
    output logic [2:0]        dbg_state
);
    localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;

    state_t            state;
    logic [N_BITS-1:0] word;
    logic [IDX_W-1:0]  idx;
    logic              prio;
    logic              pick;
    logic              cnt_room;

    assign dbg_state = state;
    assign cnt_room  = (hit_count < CNT_W'(N_BITS));

    // Handshake: a request is honoured only if still high when sampled in IDLE;
    // the grant pulse is the acknowledgement. On a tie, prio names the winner.
    always_comb begin
        pick = (req0 && req1) ? prio : req1;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            owner     <= 1'b0;
            hit_vec   <= '0;
            hit_count <= '0;
            det_x     <= 1'b0;
            det_clr_n <= 1'b0;
            word      <= '0;
            idx       <= '0;
            prio      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    det_clr_n <= 1'b1;
                    det_x     <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    if (req0 || req1) begin
                        state     <= CLEAR;
                        busy      <= 1'b1;
                        det_clr_n <= 1'b0;
                        gnt0      <= ~pick;
                        gnt1      <= pick;
                        owner     <= pick;
                        prio      <= ~pick;
                        word      <= pick ? data1 : data0;
                        hit_vec   <= '0;
                        hit_count <= '0;
                    end
                end
                CLEAR: begin
                    gnt0      <= 1'b0;
                    gnt1      <= 1'b0;
                    det_clr_n <= 1'b1;
                    det_x     <= word[0];
                    idx       <= '0;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    // det_y now reflects the bit driven one cycle earlier
                    if (idx != '0) begin
                        hit_vec[idx - IDX_W'(1)] <= det_y;
                        if (det_y && cnt_room)
                            hit_count <= hit_count + CNT_W'(1);
                    end
                    if (idx == IDX_W'(N_BITS - 1)) begin
                        det_x <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        det_x <= word[idx + IDX_W'(1)];
                    end
                end
                DRAIN: begin
                    hit_vec[N_BITS-1] <= det_y;
                    if (det_y && cnt_room)
                        hit_count <= hit_count + CNT_W'(1);
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_detector_scheduler.sv
// Randomized and directed bench for detector_scheduler with a one-cycle delay
// stub standing in for the Moore detector.
module tb_detector_scheduler;
    localparam int N = 16;
    localparam int LAT = N + 2;
    localparam int PERIOD = N + 4;

    logic         clk = 1'b0;
    logic         nrst;
    logic         req0, req1;
    logic [N-1:0] data0, data1;
    logic         gnt0, gnt1, busy, done, owner;
    logic [N-1:0] hit_vec;
    logic [4:0]   hit_count;
    logic         det_x, det_clr_n;
    logic         det_y = 1'b0;
    logic [2:0]   dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int prev_gnt = 0;
    int last_srv = -1;
    logic [N-1:0] exp_q[$];

    detector_scheduler #(.N_BITS(N), .CNT_W(5)) dut (
        .clk(clk), .nrst(nrst), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1),
        .busy(busy), .done(done), .owner(owner), .hit_vec(hit_vec),
        .hit_count(hit_count), .det_x(det_x), .det_clr_n(det_clr_n),
        .det_y(det_y), .dbg_state(dbg_state)
    );

    // clock / detector stub
    always #5 clk = ~clk;
    always @(posedge clk) begin
        det_y <= det_x;
        cyc   <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, 32'({gnt0, gnt1, busy, done, owner, det_x, det_clr_n}), 32'd0);
        check({tag, "_vec"}, 32'(hit_vec), 32'd0);
        check({tag, "_cnt"}, 32'(hit_count), 32'd0);
    endtask

    // One transaction: drive requests, expect the arbitrated grant, follow the
    // bit stream and compare the captured result against the queued word.
    task automatic txn(input logic r0, input logic r1, input logic [N-1:0] d0,
                       input logic [N-1:0] d1, input bit hold, input bit interfere,
                       input int exp_gap);
        int exp_own;
        int t0;
        int clr_low;
        bit got;
        logic [N-1:0] w;
        logic [N-1:0] xs;
        logic [N-1:0] e;
        req0 = r0; req1 = r1; data0 = d0; data1 = d1;
        if (r0 && r1) exp_own = (last_srv == 0) ? 1 : 0;
        else          exp_own = r1 ? 1 : 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) got = 1'b1;
        end
        if (!got) begin
            check("gnt_timeout", 32'd0, 32'd1);
            req0 = 1'b0; req1 = 1'b0;
            return;
        end
        check("gnt0", 32'(gnt0), 32'(exp_own == 0));
        check("gnt1", 32'(gnt1), 32'(exp_own == 1));
        if (exp_gap != 0) check("gnt_gap", 32'(cyc - prev_gnt), 32'(exp_gap));
        check("clear_x", 32'(det_x), 32'd0);
        prev_gnt = cyc;
        t0 = cyc;
        w = (exp_own == 1) ? d1 : d0;
        exp_q.push_back(w);
        last_srv = exp_own;
        clr_low = (det_clr_n == 1'b0) ? 1 : 0;
        if (!hold) begin req0 = 1'b0; req1 = 1'b0; end
        if (interfere) begin data0 = ~d0; data1 = 16'h3C5A; req1 = 1'b1; end
        xs = '0;
        got = 1'b0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            if (det_clr_n == 1'b0) clr_low++;
            if (i <= N) xs[i-1] = det_x;
            else if (i == N + 1 && !done) check("drain_x", 32'(det_x), 32'd0);
            if (done) got = 1'b1;
        end
        if (!got) begin
            check("done_timeout", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check("latency", 32'(cyc - t0), 32'(LAT));
        check("det_x_seq", 32'(xs), 32'(w));
        check("clr_pulses", 32'(clr_low), 32'd1);
        check("owner", 32'(owner), 32'(exp_own));
        check("hit_vec", 32'(hit_vec), 32'(e));
        check("hit_count", 32'(hit_count), 32'($countones(e)));
        check("done_x", 32'(det_x), 32'd0);
        check("done_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_x", 32'(det_x), 32'd0);
        check("idle_clr", 32'(det_clr_n), 32'd1);
        check("hold_vec", 32'(hit_vec), 32'(e));
        check("hold_owner", 32'(owner), 32'(exp_own));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin
        bit done_seen;
        int r;
        nrst = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check("rst_release_clr", 32'(det_clr_n), 32'd1);
        check("rst_release_busy", 32'(busy), 32'd0);

        // tie held from reset: 0,1,0,1 one period apart
        txn(1'b1, 1'b1, 16'h1234, 16'hBEEF, 1'b1, 1'b0, 0);
        for (int k = 0; k < 3; k++)
            txn(1'b1, 1'b1, 16'h1234, 16'hBEEF, 1'b1, 1'b0, PERIOD);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);

        txn(1'b1, 1'b0, 16'hA5C3, 16'h0000, 1'b0, 1'b0, 0);
        txn(1'b0, 1'b1, 16'h0F0F, 16'hFFFF, 1'b0, 1'b0, 0);
        txn(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 0);

        // changes during busy must not disturb; queued req1 follows one period later
        txn(1'b1, 1'b0, 16'h5A96, 16'h0000, 1'b0, 1'b1, 0);
        txn(1'b0, 1'b1, data0, 16'h3C5A, 1'b0, 1'b0, PERIOD);

        for (int k = 0; k < 10; k++) begin
            r = $urandom_range(1, 3);
            txn(r[0], r[1], N'($urandom), N'($urandom), 1'b0, 1'b0, 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // reset in SHIFT cycle 7: abort at once, no done, then normal service
        req0 = 1'b1; data0 = 16'hA5C3;
        done_seen = 1'b0;
        for (int i = 0; i < 40 && !(gnt0 || gnt1); i++) @(negedge clk);
        check("mid_gnt0", 32'(gnt0), 32'd1);
        req0 = 1'b0;
        repeat (N / 2) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        nrst = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        nrst = 1'b1;
        exp_q.delete();
        last_srv = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        check("mid_no_done", 32'(done_seen), 32'd0);
        check("mid_clr_after", 32'(det_clr_n), 32'd1);
        txn(1'b1, 1'b1, 16'h00FF, 16'hF00F, 1'b0, 1'b0, 0);
        txn(1'b1, 1'b0, 16'hA5C3, 16'h0000, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
